// File: rtl/chacha20_poly1305_tag_verify.sv
// chacha20_poly1305_tag_verify: constant-time compare of received vs computed Poly1305 tag
module chacha20_poly1305_tag_verify (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start,
   input  logic         rx_tag_we,
   input  logic [1:0]   rx_tag_addr,
   input  logic [31:0]  rx_tag_data,
   input  logic         calc_tag_valid,
   input  logic [127:0] calc_tag,
   output logic         ready,
   output logic         done,
   output logic         tag_correct,
   output logic [7:0]   fail_count
);
   typedef enum logic [1:0] {IDLE, LOAD, COMPARE, DONE} state_t;
   state_t state, state_nxt;
   logic [3:0][31:0] rx_word;
   logic [3:0][31:0] calc_word;
   logic [3:0]       rx_loaded, rx_loaded_nxt;
   logic             calc_loaded, calc_loaded_nxt;
   logic [1:0]       word_ctr;
   logic [31:0]      diff_acc, diff_nxt;
   logic             load_we, load_calc;
   // the compare is entered on the same edge that captures the final input
   always_comb begin
      load_we         = state == LOAD && rx_tag_we;
      load_calc       = state == LOAD && calc_tag_valid;
      rx_loaded_nxt   = rx_loaded | (load_we ? 4'b0001 << rx_tag_addr : 4'b0000);
      calc_loaded_nxt = calc_loaded | load_calc;
      diff_nxt        = diff_acc | (rx_word[word_ctr] ^ calc_word[word_ctr]);
      state_nxt       = start ? LOAD :
                        (state == LOAD && &rx_loaded_nxt && calc_loaded_nxt) ? COMPARE :
                        (state == COMPARE && word_ctr == 2'd3) ? DONE : state;
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         rx_word     <= '0;
         calc_word   <= '0;
         rx_loaded   <= '0;
         calc_loaded <= 1'b0;
         word_ctr    <= '0;
         diff_acc    <= '0;
         fail_count  <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            rx_loaded   <= '0;
            calc_loaded <= 1'b0;
            word_ctr    <= '0;
            diff_acc    <= '0;
         end else begin
            rx_loaded   <= rx_loaded_nxt;
            calc_loaded <= calc_loaded_nxt;
            if (load_we) rx_word[rx_tag_addr] <= rx_tag_data;
            if (load_calc) calc_word <= calc_tag;
            if (state == COMPARE) begin
               word_ctr <= word_ctr + 2'd1;
               diff_acc <= diff_nxt;
               if (word_ctr == 2'd3 && diff_nxt != '0 && fail_count != 8'hff)
                  fail_count <= fail_count + 8'd1;
            end
         end
      end
   end
   assign ready       = state == IDLE || state == DONE;
   assign done        = state == DONE;
   assign tag_correct = state == DONE && diff_acc == '0;
endmodule

// File: tb/tb_chacha20_poly1305_tag_verify.sv
// tb_chacha20_poly1305_tag_verify: randomized scenario bench with a whole-tag reference model
module tb_chacha20_poly1305_tag_verify;
   logic         clk = 0, reset_n = 0, start = 0, rx_tag_we = 0, calc_tag_valid = 0;
   logic [1:0]   rx_tag_addr = 0;
   logic [31:0]  rx_tag_data = 0;
   logic [127:0] calc_tag = 0;
   logic         ready, done, tag_correct;
   logic [7:0]   fail_count;
   int errors = 0, checks = 0, m_fail = 0;
   localparam logic [127:0] GOOD = 128'h0f0e0d0c_0b0a0908_07060504_03020100;

   chacha20_poly1305_tag_verify dut (
      .clk(clk), .reset_n(reset_n), .start(start), .rx_tag_we(rx_tag_we),
      .rx_tag_addr(rx_tag_addr), .rx_tag_data(rx_tag_data),
      .calc_tag_valid(calc_tag_valid), .calc_tag(calc_tag),
      .ready(ready), .done(done), .tag_correct(tag_correct), .fail_count(fail_count)
   );

   always #5 clk = ~clk;

   task automatic tick; @(posedge clk); #1; endtask
   task automatic pulse_start; start = 1; tick(); start = 0; endtask
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      rx_tag_we = 1; rx_tag_addr = a; rx_tag_data = d; tick(); rx_tag_we = 0;
   endtask
   task automatic calc(input logic [127:0] c);
      calc_tag_valid = 1; calc_tag = c; tick(); calc_tag_valid = 0;
   endtask

   // one complete transaction: the whole tags are compared as 128-bit values
   task automatic run_tag(input logic [127:0] rxv, input logic [127:0] cv, input string nm);
      int lat;
      bit early, exp;
      pulse_start();
      for (int i = 0; i < 4; i++) wr(2'(i), rxv[32*i +: 32]);
      calc(cv);
      exp = (rxv == cv);
      if (!exp && m_fail < 255) m_fail++;
      lat = 1; early = 0;
      while (!done && lat < 12) begin
         if (tag_correct) early = 1;
         tick(); lat++;
      end
      checks++; if (lat !== 5) begin errors++; $display("FAIL %s latency got %0d want 5", nm, lat); end
      checks++; if (done !== 1'b1 || tag_correct !== exp) begin errors++; $display("FAIL %s result done=%b tag_correct=%b want 1/%b", nm, done, tag_correct, exp); end
      checks++; if (fail_count !== 8'(m_fail)) begin errors++; $display("FAIL %s fail_count got %0d want %0d", nm, fail_count, m_fail); end
      checks++; if (early) begin errors++; $display("FAIL %s tag_correct high before done got 1 want 0", nm); end
   endtask

   task automatic test_reset;
      checks++; if ({ready, done, tag_correct, fail_count} !== {3'b100, 8'h00}) begin errors++; $display("FAIL reset outputs got %b%b%b/%0d want 100/0", ready, done, tag_correct, fail_count); end
   endtask

   task automatic test_match; run_tag(GOOD, GOOD, "match"); endtask

   task automatic test_single_bit;
      run_tag(GOOD ^ (128'b1 << 127), GOOD, "w3b31");
      run_tag(GOOD ^ 128'b1, GOOD, "w0b0");
   endtask

   task automatic test_random;
      for (int k = 0; k < 10; k++) begin
         logic [127:0] r;
         r = {$urandom, $urandom, $urandom, $urandom};
         run_tag(r, ($urandom_range(1) == 1) ? r : r ^ (128'b1 << $urandom_range(127)), "random");
      end
   endtask

   task automatic test_ordering;
      int lat;
      logic [127:0] bad;
      bad = ~GOOD;
      pulse_start();
      calc(bad);
      wr(0, GOOD[31:0]);
      wr(1, 32'hdeadbeef);
      wr(1, GOOD[63:32]);
      wr(2, GOOD[95:64]);
      rx_tag_we = 1; rx_tag_addr = 3; rx_tag_data = GOOD[127:96];
      calc_tag_valid = 1; calc_tag = GOOD;
      tick();
      rx_tag_we = 0; calc_tag_valid = 0;
      lat = 1;
      while (!done && lat < 12) begin tick(); lat++; end
      checks++; if (lat !== 5) begin errors++; $display("FAIL ordering latency got %0d want 5", lat); end
      checks++; if (tag_correct !== 1'b1 || fail_count !== 8'(m_fail)) begin errors++; $display("FAIL ordering tag_correct=%b fail_count=%0d want 1/%0d", tag_correct, fail_count, m_fail); end
   endtask

   task automatic test_incomplete;
      bit seen;
      pulse_start();
      for (int i = 0; i < 3; i++) wr(2'(i), GOOD[32*i +: 32]);
      calc(GOOD);
      seen = 0;
      repeat (20) begin if (done) seen = 1; tick(); end
      checks++; if (seen || done !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL incomplete done seen=%b done=%b ready=%b want 0/0/0", seen, done, ready); end
      wr(3, GOOD[127:96]);
      repeat (6) if (!done) tick();
      checks++; if (done !== 1'b1 || tag_correct !== 1'b1) begin errors++; $display("FAIL complete_late done=%b tag_correct=%b want 1/1", done, tag_correct); end
      wr(0, ~GOOD[31:0]);
      tick();
      checks++; if (done !== 1'b1 || tag_correct !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL write_in_done done=%b tag_correct=%b ready=%b want 1/1/1", done, tag_correct, ready); end
   endtask

   task automatic test_abort;
      bit seen;
      int fc;
      fc = m_fail;
      pulse_start();
      for (int i = 0; i < 4; i++) wr(2'(i), ~GOOD[32*i +: 32]);
      calc(GOOD);
      tick();
      pulse_start();
      checks++; if (ready !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort state ready=%b done=%b want 0/0", ready, done); end
      seen = 0;
      repeat (8) begin if (done) seen = 1; tick(); end
      checks++; if (seen || fail_count !== 8'(fc)) begin errors++; $display("FAIL abort done_seen=%b fail_count=%0d want 0/%0d", seen, fail_count, fc); end
      start = 1; rx_tag_we = 1; rx_tag_addr = 0; rx_tag_data = GOOD[31:0];
      tick();
      start = 0; rx_tag_we = 0;
      for (int i = 1; i < 4; i++) wr(2'(i), GOOD[32*i +: 32]);
      calc(GOOD);
      seen = 0;
      repeat (10) begin if (done) seen = 1; tick(); end
      checks++; if (seen) begin errors++; $display("FAIL start_drops_write done got 1 want 0"); end
      wr(0, GOOD[31:0]);
      repeat (6) if (!done) tick();
      checks++; if (done !== 1'b1 || tag_correct !== 1'b1) begin errors++; $display("FAIL after_drop done=%b tag_correct=%b want 1/1", done, tag_correct); end
   endtask

   task automatic test_saturation;
      for (int k = 0; k < 256; k++)
         run_tag(GOOD ^ (128'b1 << $urandom_range(127)), GOOD, "saturate");
      run_tag(GOOD, ~GOOD, "saturate_hold");
      checks++; if (fail_count !== 8'hff) begin errors++; $display("FAIL saturation fail_count got %0d want 255", fail_count); end
   endtask

   task automatic test_reset_in_done;
      reset_n = 0; tick(); reset_n = 1;
      m_fail = 0;
      checks++; if ({ready, done, tag_correct, fail_count} !== {3'b100, 8'h00}) begin errors++; $display("FAIL reset_in_done got %b%b%b/%0d want 100/0", ready, done, tag_correct, fail_count); end
      run_tag(GOOD, GOOD ^ (128'b1 << 64), "post_reset");
   endtask

   initial begin
      repeat (2) tick();
      reset_n = 1;
      tick();
      test_reset();
      test_match();
      test_single_bit();
      test_random();
      test_ordering();
      test_incomplete();
      test_abort();
      test_saturation();
      test_reset_in_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
